// File: rtl/cla_sub_pkg.sv
// rtl/cla_sub_pkg.sv - shared FSM state type and slice-count helper for the sequential CLA subtractor
package cla_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int slice_count(input int w, input int d);
        return w / d;
    endfunction

endpackage

// File: rtl/cla_sub_slice.sv
// rtl/cla_sub_slice.sv - D-bit combinational carry-lookahead adder slice
// Every carry is expanded from generate/propagate and c_in directly, never from a lower carry.
module cla_sub_slice #(
    parameter int D = 4
) (
    input  logic [D-1:0] x,
    input  logic [D-1:0] y,
    input  logic         c_in,
    output logic [D-1:0] sum,
    output logic         c_out
);

    logic [D-1:0] w_g;
    logic [D-1:0] w_p;
    logic [D:0]   w_c;
    logic         w_term;
    logic         w_run;
    logic         w_acc;

    assign w_g = x & y;
    assign w_p = x ^ y;

    always_comb begin
        w_c    = '0;
        w_term = 1'b0;
        w_run  = 1'b0;
        w_acc  = 1'b0;
        w_c[0] = c_in;
        for (int i = 0; i < D; i++) begin
            // c[i+1] = P[i:0]&c_in | OR_j ( G[j] & P[i:j+1] )
            w_term = c_in;
            for (int j = 0; j <= i; j++) begin
                w_term = w_term & w_p[j];
            end
            w_acc = w_term;
            for (int j = 0; j <= i; j++) begin
                w_run = w_g[j];
                for (int m = j + 1; m <= i; m++) begin
                    w_run = w_run & w_p[m];
                end
                w_acc = w_acc | w_run;
            end
            w_c[i+1] = w_acc;
        end
    end

    assign sum   = w_p ^ w_c[D-1:0];
    assign c_out = w_c[D];

endmodule

// File: rtl/carry_lookahead_subtractor_seq.sv
// rtl/carry_lookahead_subtractor_seq.sv - sequential a - b - b_in, one D-bit lookahead slice per cycle
// Optional CLA_SUB_OVERFLOW_EN adds the two's-complement overflow output ovf.
module carry_lookahead_subtractor_seq
    import cla_sub_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] d,
    output logic         b_out
`ifdef CLA_SUB_OVERFLOW_EN
    ,
    output logic         ovf
`endif
);

    localparam int N  = slice_count(W, D);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_nb;
    logic [W-1:0]  r_d;
    logic          r_carry;
    logic          r_bout;
    logic [KW-1:0] r_k;

    logic [D-1:0]   w_sum;
    logic           w_cout;
    logic [W+D-1:0] w_a_ext;
    logic [W+D-1:0] w_nb_ext;
    logic [W+D-1:0] w_d_ext;

    // Operands shift right so the active slice always sits in the low D bits;
    // results enter from the top so slice 0 lands in d[D-1:0] after N shifts.
    assign w_a_ext  = {{D{1'b0}}, r_a};
    assign w_nb_ext = {{D{1'b0}}, r_nb};
    assign w_d_ext  = {w_sum, r_d};

    cla_sub_slice #(
        .D (D)
    ) u_slice (
        .x     (r_a[D-1:0]),
        .y     (r_nb[D-1:0]),
        .c_in  (r_carry),
        .sum   (w_sum),
        .c_out (w_cout)
    );

`ifdef CLA_SUB_OVERFLOW_EN
    logic r_ovf;
    // On the last slice the low D bits hold the original MSB slice of a and ~b.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && r_k == K_LAST) begin
            r_ovf <= (r_a[D-1] ^ ~r_nb[D-1]) & (r_a[D-1] ^ w_sum[D-1]);
        end
    end
    assign ovf = r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_nb    <= '0;
            r_d     <= '0;
            r_carry <= 1'b0;
            r_bout  <= 1'b0;
            r_k     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_nb    <= ~b;
                        r_carry <= ~b_in;
                        r_k     <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= w_a_ext[W+D-1:D];
                    r_nb    <= w_nb_ext[W+D-1:D];
                    r_d     <= w_d_ext[W+D-1:D];
                    r_carry <= w_cout;
                    r_k     <= r_k + 1'b1;
                    if (r_k == K_LAST) begin
                        r_bout  <= ~w_cout;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign d         = r_d;
    assign b_out     = r_bout;

endmodule
